btb_update_unit: RTL and testbench

Branch target buffer with fetch-side lookup and execute-side resolution/update. Holds per-entry valid, tag, 2-bit prediction state and target; answers fetch-stage predictions combinationally and, one cycle after a branch resolves in execute, writes back the updated state, raises a registered redirect on misprediction and keeps saturating branch/mispredict statistics. It sits between the IF stage PC mux and the EX-stage branch comparator.

---
 rtl/btb_update_unit_pkg.sv | 30 +++
 rtl/btb_update_unit_bp_sat_counter.sv | 31 +++
 rtl/btb_update_unit.sv | 134 +++++++++++++
 tb/tb_btb_update_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_unit_pkg.sv
// Shared definitions for the branch target buffer: prediction state
// encodings, entry field widths and PC index/tag extraction helpers.
package btb_update_unit_pkg;

  localparam int PC_W    = 32;
  localparam int STATE_W = 2;

  // 2-bit saturating prediction states; bit 1 is the taken prediction
  localparam logic [STATE_W-1:0] SNT = 2'b00;
  localparam logic [STATE_W-1:0] WNT = 2'b01;
  localparam logic [STATE_W-1:0] WT  = 2'b10;
  localparam logic [STATE_W-1:0] ST  = 2'b11;

  // Entry state written when a taken branch allocates a fresh entry
  localparam logic [STATE_W-1:0] ALLOC_STATE = WT;

  // Word-aligned index: pc[idx_w+1:2], returned zero-extended
  function automatic logic [PC_W-1:0] pc_index(input logic [PC_W-1:0] pc,
                                               input int idx_w);
    return (pc >> 2) & ((32'h1 << idx_w) - 32'h1);
  endfunction

  // Tag bits directly above the index: pc[idx_w+tag_w+1:idx_w+2]
  function automatic logic [PC_W-1:0] pc_tag(input logic [PC_W-1:0] pc,
                                             input int idx_w,
                                             input int tag_w);
    return (pc >> (idx_w + 2)) & ((32'h1 << tag_w) - 32'h1);
  endfunction

endpackage

// File: rtl/btb_update_unit_bp_sat_counter.sv
// Combinational next-state for one 2-bit branch prediction counter.
//   state | meaning
//   SNT   | strong not-taken
//   WNT   | weak not-taken
//   WT    | weak taken
//   ST    | strong taken
// Note WNT jumps straight to ST on taken, and ST drops to WT on not-taken.
module bp_sat_counter
  import btb_update_unit_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_taken,
  output logic [STATE_W-1:0] o_next_state,
  output logic               o_pred
);

  // Next state from current state and resolved outcome
  always_comb begin
    o_next_state = i_state;
    unique case (i_state)
      SNT: o_next_state = i_taken ? WNT : SNT;
      WNT: o_next_state = i_taken ? ST  : SNT;
      WT:  o_next_state = i_taken ? ST  : SNT;
      ST:  o_next_state = i_taken ? ST  : WT;
      default: o_next_state = SNT;
    endcase
  end

  assign o_pred = i_state[1];

endmodule

// File: rtl/btb_update_unit.sv
// Branch target buffer: combinational fetch-side lookup, execute-side
// resolution that updates/allocates entries one edge later, a registered
// mispredict redirect and saturating branch/mispredict statistics.
module btb_update_unit
  import btb_update_unit_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               r_valid  [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [STATE_W-1:0] r_state  [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  logic               r_redirect_valid;
  logic [31:0]        r_redirect_pc;
  logic [CNT_W-1:0]   r_branch_cnt;
  logic [CNT_W-1:0]   r_mispred_cnt;

  logic [IDX_W-1:0]   w_if_idx;
  logic [TAG_W-1:0]   w_if_tag;
  logic               w_if_hit;
  logic [IDX_W-1:0]   w_ex_idx;
  logic [TAG_W-1:0]   w_ex_tag;
  logic               w_ex_hit;
  logic               w_resolve;
  logic               w_mispred;
  logic [STATE_W-1:0] w_next_state;
  logic               w_ex_entry_pred;
  logic [31:0]        w_redirect_pc;

  // Fetch-side lookup: purely combinational, reads pre-write contents
  assign w_if_idx    = IDX_W'(pc_index(if_pc, IDX_W));
  assign w_if_tag    = TAG_W'(pc_tag(if_pc, IDX_W, TAG_W));
  assign w_if_hit    = if_valid & r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
  assign pred_hit    = w_if_hit;
  assign pred_taken  = w_if_hit & r_state[w_if_idx][1];
  assign pred_target = w_if_hit ? r_target[w_if_idx] : 32'h0;

  // Execute-side read port and resolution decode
  assign w_ex_idx  = IDX_W'(pc_index(ex_pc, IDX_W));
  assign w_ex_tag  = TAG_W'(pc_tag(ex_pc, IDX_W, TAG_W));
  assign w_ex_hit  = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
  assign w_resolve = ex_valid & ex_is_branch;
  assign w_mispred = w_resolve &
                     ((ex_taken != ex_pred_taken) |
                      (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign w_redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

  bp_sat_counter u_sat_counter (
    .i_state      (r_state[w_ex_idx]),
    .i_taken      (ex_taken),
    .o_next_state (w_next_state),
    .o_pred       (w_ex_entry_pred)
  );

  // Table write: update on hit, allocate on taken miss, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_state[i]  <= SNT;
        r_target[i] <= 32'h0;
      end
    end else if (w_resolve) begin
      if (w_ex_hit) begin
        r_state[w_ex_idx] <= w_next_state;
        if (ex_taken) r_target[w_ex_idx] <= ex_target;
      end else if (ex_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_state[w_ex_idx]  <= ALLOC_STATE;
        r_target[w_ex_idx] <= ex_target;
      end
    end
  end

  // Redirect register: pulses each mispredict cycle, pc holds between
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'h0;
    end else begin
      r_redirect_valid <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_redirect_pc;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve && r_branch_cnt != CNT_MAX) r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_mispred && r_mispred_cnt != CNT_MAX) r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign branch_cnt     = r_branch_cnt;
  assign mispred_cnt    = r_mispred_cnt;

  // The entry prediction is exposed by the counter for debug only
  logic w_unused;
  assign w_unused = w_ex_entry_pred;

endmodule

// File: tb/tb_btb_update_unit.sv
// Directed bench for btb_update_unit with a scoreboard queue of expected
// output values; CNT_W is reduced to 4 so saturation is reachable quickly.
module tb_btb_update_unit;

  localparam int CNT_W = 4;
  localparam logic [31:0] CMAX = 32'd15;

  logic             clk;
  logic             rst_n;
  logic             if_valid;
  logic [31:0]      if_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid;
  logic             ex_is_branch;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  btb_update_unit #(.ENTRIES(32), .IDX_W(5), .TAG_W(8), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] m_bc    = 0;
  logic [31:0] m_mc    = 0;
  logic [31:0] m_rpc   = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return {31'h0, redirect_valid};
      1: return redirect_pc;
      2: return {28'h0, branch_cnt};
      3: return {28'h0, mispred_cnt};
      4: return {31'h0, pred_hit};
      5: return {31'h0, pred_taken};
      default: return pred_target;
    endcase
  endfunction

  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", e.name, obs, e.val);
    end
  endtask

  task automatic push_regs(input string tag, input logic rv);
    push({tag, ".redirect_valid"}, 0, {31'h0, rv});
    push({tag, ".redirect_pc"}, 1, m_rpc);
    push({tag, ".branch_cnt"}, 2, m_bc);
    push({tag, ".mispred_cnt"}, 3, m_mc);
  endtask

  task automatic lookup_chk(input string tag, input logic [31:0] pc,
                            input logic hit, input logic tk, input logic [31:0] tgt);
    if_valid = 1'b1;
    if_pc    = pc;
    #1;
    push({tag, ".pred_hit"}, 4, {31'h0, hit});
    push({tag, ".pred_taken"}, 5, {31'h0, tk});
    push({tag, ".pred_target"}, 6, tgt);
    check_sb();
  endtask

  // One resolve cycle; expected mispredict and redirect pc are given directly
  task automatic resolve(input string tag, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic exp_m, input logic [31:0] exp_rpc);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    if (m_bc != CMAX) m_bc = m_bc + 1;
    if (exp_m) begin
      if (m_mc != CMAX) m_mc = m_mc + 1;
      m_rpc = exp_rpc;
    end
    push_regs(tag, exp_m);
    @(posedge clk);
    #1;
    check_sb();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
  endtask

  task automatic idle(input string tag);
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    push_regs(tag, 1'b0);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b0; if_pc = 32'h0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0;
    ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    #12;
    push_regs("reset", 1'b0);
    check_sb();
    lookup_chk("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // taken miss with not-taken prediction: allocate WT, redirect to target
    resolve("alloc", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    lookup_chk("alloc_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
    idle("pulse_end");
    lookup_chk("no_fetch", 32'h100, 1'b1, 1'b1, 32'h200);
    if_valid = 1'b0;
    #1;
    push("if_valid_low.pred_hit", 4, 32'h0);
    push("if_valid_low.pred_target", 6, 32'h0);
    check_sb();

    // correct taken predictions: WT -> ST -> ST
    resolve("taken_ok1", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
    resolve("taken_ok2", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
    // not-taken from ST -> WT, redirect to pc+4, still predicts taken
    resolve("nt_from_st", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    lookup_chk("wt_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
    // back-to-back mispredicts: WT -> SNT, then a not-taken miss (no alloc)
    resolve("b2b_m1", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    resolve("b2b_m2", 32'h300, 1'b0, 32'h0, 1'b1, 32'h380, 1'b1, 32'h304);
    lookup_chk("snt_lookup", 32'h100, 1'b1, 1'b0, 32'h200);
    lookup_chk("nt_miss_noalloc", 32'h300, 1'b0, 1'b0, 32'h0);
    // taken with matching direction but wrong target: SNT -> WNT, new target
    resolve("tgt_mismatch", 32'h100, 1'b1, 32'h240, 1'b1, 32'h200, 1'b1, 32'h240);
    lookup_chk("wnt_lookup", 32'h100, 1'b1, 1'b0, 32'h240);
    // WNT taken jumps straight to ST
    resolve("wnt_to_st", 32'h100, 1'b1, 32'h240, 1'b0, 32'h0, 1'b1, 32'h240);
    lookup_chk("st_lookup", 32'h100, 1'b1, 1'b1, 32'h240);

    // ex_is_branch without ex_valid is ignored
    ex_valid = 1'b0; ex_is_branch = 1'b1; ex_pc = 32'h100; ex_taken = 1'b0;
    ex_pred_taken = 1'b1;
    push_regs("ignored", 1'b0);
    @(posedge clk);
    #1;
    check_sb();
    ex_is_branch = 1'b0;
    lookup_chk("ignored_lookup", 32'h100, 1'b1, 1'b1, 32'h240);

    // aliasing: 0x500 shares index 0 with 0x100 and overwrites it
    resolve("alias", 32'h500, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 32'h600);
    lookup_chk("alias_old_miss", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup_chk("alias_new_hit", 32'h500, 1'b1, 1'b1, 32'h600);

    // same-cycle lookup and update: old contents now, new next cycle
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h500; ex_taken = 1'b0;
    ex_target = 32'h0; ex_pred_taken = 1'b1; ex_pred_target = 32'h600;
    lookup_chk("same_cycle_old", 32'h500, 1'b1, 1'b1, 32'h600);
    resolve("same_cycle_upd", 32'h500, 1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 32'h504);
    lookup_chk("same_cycle_new", 32'h500, 1'b1, 1'b0, 32'h600);

    // asynchronous reset while redirect_valid is high
    push("pre_reset.redirect_valid", 0, 32'h1);
    check_sb();
    #1;
    rst_n = 1'b0;
    #1;
    m_bc = 0; m_mc = 0; m_rpc = 0;
    push_regs("async_reset", 1'b0);
    check_sb();
    lookup_chk("async_reset_lookup", 32'h500, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // saturation: 17 mispredicting resolves on 4-bit counters
    for (int i = 0; i < 17; i++) begin
      resolve("sat", 32'h1000 + 32'(i) * 4, 1'b1, 32'h2000 + 32'(i) * 4, 1'b0, 32'h0,
              1'b1, 32'h2000 + 32'(i) * 4);
    end
    push("sat_final.branch_cnt", 2, CMAX);
    push("sat_final.mispred_cnt", 3, CMAX);
    check_sb();
    resolve("sat_hold", 32'h1000, 1'b1, 32'h2000, 1'b1, 32'h2000, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
